term_char_writer: RTL and testbench
===================================

# term_char_writer

Cursor-managing character writer that sits directly upstream of the display terminal's write port. Accepts a stream of 6-bit character codes and control commands over a valid/ready handshake, tracks the cursor, and issues one cell write per cycle (`w_h_addr`, `w_v_addr`, `w_data`, `w_en`). It also performs line wrap, newline, backspace, and whole-screen clear by sweeping space characters into the terminal memory.

## Interface

- `COLS`, default 10: character columns; valid range 2..255.
- `ROWS`, default 6: character rows; valid range 2..255.
- `CLEAR_ON_RESET`, default 1: when 1, a full-screen clear runs automatically after reset release.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: command/character present.
- `in_ready` out 1: writer can accept; a transfer occurs on a rising edge with `in_valid && in_ready`.
- `in_cmd` in 2: `CMD_PRINT`=0, `CMD_NEWLINE`=1, `CMD_BACKSPACE`=2, `CMD_CLEAR`=3.
- `in_char` in 6: character code; used only for `CMD_PRINT`.
- `w_h_addr` out 8: column of the cell write, zero-extended.
- `w_v_addr` out 8: row of the cell write, zero-extended.
- `w_data` out 6: character code written.
- `w_en` out 1: write strobe, one cell per cycle.
- `cur_h` out 8: current cursor column.
- `cur_v` out 8: current cursor row.
- `busy` out 1: a sweep (line or screen clear) is in progress.

## Operation

- States:
  - `IDLE`
  - `EMIT`: single write.
  - `CLR_LINE`: write spaces across row `cur_v`.
  - `CLR_ALL`: row-major sweep of all cells.
- All outputs are registered.
- `in_ready` = (state == `IDLE`) and `rst` deasserted.
- `CMD_PRINT`:
  - `EMIT` writes `in_char` at (`cur_h`,`cur_v`).
  - If `cur_h` < `COLS`-1: `cur_h`+1, then → `IDLE`.
  - Else: `cur_h`=0, `cur_v` = (`cur_v`+1) mod `ROWS`, then → `CLR_LINE` on the new row.
- `CMD_NEWLINE`: `cur_h`=0, `cur_v` = (`cur_v`+1) mod `ROWS`, → `CLR_LINE`.
- `CMD_BACKSPACE`:
  - If `cur_h` > 0: `cur_h`-1.
  - Else if `cur_v` > 0: `cur_v`-1, `cur_h`=`COLS`-1.
  - Either case: `EMIT` writes `CHAR_SPACE` at the new cursor.
  - At (0,0): no write, no cursor change; returns to `IDLE` after one cycle.
- `CMD_CLEAR`: → `CLR_ALL`, writing `CHAR_SPACE` to rows 0..`ROWS`-1, columns 0..`COLS`-1. The cursor ends at (0,0).
- `CLR_LINE` writes columns 0..`COLS`-1 of `cur_v`. The cursor is unchanged.
- `in_char` and `in_cmd` are captured on acceptance. Later input changes have no effect until the next acceptance.
- Wrap from row `ROWS`-1 goes to row 0. There is no scrolling: the old contents of the target row are erased by `CLR_LINE`.

## Timing

- Reset values:
  - `w_en`=0, `w_h_addr`=0, `w_v_addr`=0, `w_data`=0.
  - `cur_h`=0, `cur_v`=0.
  - `in_ready`=0.
  - `busy` = `CLEAR_ON_RESET`.
  - State = `CLR_ALL` if `CLEAR_ON_RESET`, else `IDLE`.
- Acceptance at edge N puts the write on the outputs (`w_en`=1) for cycle N..N+1.
- `in_ready` is low for exactly 1 cycle after a print or backspace, so throughput is 1 character per 2 cycles.
- `CLR_LINE`: `COLS` consecutive `w_en` cycles, `busy`=1. `in_ready` rises the cycle after the last write.
- `CLR_ALL`: `ROWS`*`COLS` consecutive `w_en` cycles.
- `w_en` is 0 in every cycle without a write. Address and data hold their last values.
- `cur_h`/`cur_v` update on the same edge that launches the corresponding write.
- Reset asserted mid-sweep aborts immediately: outputs go to reset values asynchronously. The sweep restarts from (0,0) only if `CLEAR_ON_RESET`.
- `in_valid` while `in_ready`=0 is held off; no command is dropped or duplicated.

## Structure

- Shared constants live in the shared package (`const.v`):
  - `CHAR_SPACE`.
  - `CMD_*` encodings, next to the existing `CHAR_*` codes.
  - State encodings.
- One sub-module: `term_sweep_ctr`, a column/row sweep counter.
  - Inputs: start, row-only/full mode.
  - Outputs: h, v, active, last.
  - Used by both `CLR_LINE` and `CLR_ALL`.

## Test plan

- Reset release with `CLEAR_ON_RESET`=1, `COLS`=10, `ROWS`=6 -> exactly 60 `w_en` cycles, `w_data`=`CHAR_SPACE` at (0,0)..(9,5) row-major; then `in_ready`=1 and cursor (0,0).
- Print `CHAR_A`, `CHAR_N`, `CHAR_T` -> writes (0,0)=A, (1,0)=N, (2,0)=T on alternating cycles; cursor ends at (3,0).
- 10 prints on row 5 -> 10th write lands at (9,5); cursor wraps to (0,0); 10 space writes to row 0 with `busy`=1.
- Backspace at (0,2) -> space written at (9,1), cursor (9,1); backspace at (0,0) -> no `w_en`, cursor stays (0,0).
- Newline from (4,3) -> cursor (0,4), 10 space writes on row 4; `in_valid` held high throughout with `CMD_PRINT` `CHAR_W`, and W is written exactly once, at (0,4).
- `rst` asserted at write 30 of `CMD_CLEAR` -> `w_en`=0 immediately; after release a fresh 60-cycle sweep starts at (0,0).

Source files
------------

// File: rtl/term_char_writer_pkg.sv
// term_char_writer_pkg: character codes, command encodings and writer states
package term_char_writer_pkg;
  localparam logic [5:0] CHAR_A = 6'd1;
  localparam logic [5:0] CHAR_N = 6'd14;
  localparam logic [5:0] CHAR_T = 6'd20;
  localparam logic [5:0] CHAR_W = 6'd23;
  localparam logic [5:0] CHAR_SPACE = 6'd32;
  localparam logic [1:0] CMD_PRINT = 2'd0;
  localparam logic [1:0] CMD_NEWLINE = 2'd1;
  localparam logic [1:0] CMD_BACKSPACE = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;
  typedef enum logic [1:0] {IDLE, EMIT, CLR_LINE, CLR_ALL} state_t;
endpackage

// File: rtl/term_char_writer_sweep.sv
// term_sweep_ctr: holds the next cell of a line or full-screen sweep; runs while active
module term_sweep_ctr import term_char_writer_pkg::*; #(
  parameter int COLS = 10,
  parameter int ROWS = 6,
  parameter bit RUN_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       full,
  output logic [7:0] h,
  output logic [7:0] v,
  output logic       active,
  output logic       last
);
  logic full_q;
  assign last = active && h == 8'(COLS - 1) && (!full_q || v == 8'(ROWS - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      h <= '0;
      v <= '0;
      active <= RUN_ON_RESET;
      full_q <= 1'b1;
    end else if (start) begin
      h <= '0;
      v <= '0;
      active <= 1'b1;
      full_q <= full;
    end else if (active) begin
      h <= (h == 8'(COLS - 1)) ? 8'd0 : h + 8'd1;
      v <= (h == 8'(COLS - 1) && !last) ? v + 8'd1 : v;
      active <= !last;
    end
endmodule

// File: rtl/term_char_writer.sv
// term_char_writer: cursor-tracking character writer feeding the terminal cell-write port
module term_char_writer import term_char_writer_pkg::*; #(
  parameter int COLS = 10,
  parameter int ROWS = 6,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_cmd,
  input  logic [5:0] in_char,
  output logic [7:0] w_h_addr,
  output logic [7:0] w_v_addr,
  output logic [5:0] w_data,
  output logic       w_en,
  output logic [7:0] cur_h,
  output logic [7:0] cur_v,
  output logic       busy
);
  state_t state, state_n;
  logic [7:0] wh_n, wv_n, ch_n, cv_n, nxt_v, sh, sv;
  logic [5:0] wd_n;
  logic w_en_n, start, full, active, last, accept;
  term_sweep_ctr #(.COLS(COLS), .ROWS(ROWS), .RUN_ON_RESET(CLEAR_ON_RESET)) u_sweep (
    .clk(clk), .rst(rst), .start(start), .full(full),
    .h(sh), .v(sv), .active(active), .last(last)
  );
  assign accept = in_valid && in_ready;
  // A running sweep always owns the write port; its final cell drains through EMIT
  // so in_ready only rises once that write has been presented.
  always_comb begin
    state_n = state;
    w_en_n = 1'b0;
    wh_n = w_h_addr;
    wv_n = w_v_addr;
    wd_n = w_data;
    ch_n = cur_h;
    cv_n = cur_v;
    start = 1'b0;
    full = 1'b0;
    nxt_v = (cur_v == 8'(ROWS - 1)) ? 8'd0 : cur_v + 8'd1;
    if (active) begin
      w_en_n = 1'b1;
      wh_n = sh;
      wv_n = (state == CLR_ALL) ? sv : cur_v;
      wd_n = CHAR_SPACE;
      state_n = last ? EMIT : (state == CLR_ALL ? CLR_ALL : CLR_LINE);
    end else if (state != IDLE) begin
      state_n = IDLE;
    end else if (accept) begin
      case (in_cmd)
        CMD_PRINT: begin
          w_en_n = 1'b1;
          wh_n = cur_h;
          wv_n = cur_v;
          wd_n = in_char;
          state_n = EMIT;
          start = cur_h == 8'(COLS - 1);
          ch_n = start ? 8'd0 : cur_h + 8'd1;
          cv_n = start ? nxt_v : cur_v;
        end
        CMD_NEWLINE: begin
          ch_n = 8'd0;
          cv_n = nxt_v;
          start = 1'b1;
          state_n = CLR_LINE;
        end
        CMD_BACKSPACE: begin
          state_n = EMIT;
          if (cur_h != 8'd0 || cur_v != 8'd0) begin
            ch_n = (cur_h != 8'd0) ? cur_h - 8'd1 : 8'(COLS - 1);
            cv_n = (cur_h != 8'd0) ? cur_v : cur_v - 8'd1;
            w_en_n = 1'b1;
            wh_n = ch_n;
            wv_n = cv_n;
            wd_n = CHAR_SPACE;
          end
        end
        default: begin
          ch_n = 8'd0;
          cv_n = 8'd0;
          start = 1'b1;
          full = 1'b1;
          state_n = CLR_ALL;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
      w_en <= 1'b0;
      w_h_addr <= '0;
      w_v_addr <= '0;
      w_data <= '0;
      cur_h <= '0;
      cur_v <= '0;
      in_ready <= 1'b0;
      busy <= CLEAR_ON_RESET;
    end else begin
      state <= state_n;
      w_en <= w_en_n;
      w_h_addr <= wh_n;
      w_v_addr <= wv_n;
      w_data <= wd_n;
      cur_h <= ch_n;
      cur_v <= cv_n;
      in_ready <= state_n == IDLE;
      busy <= active || state_n == CLR_LINE || state_n == CLR_ALL;
    end
endmodule

// File: tb/tb_term_char_writer.sv
// tb_term_char_writer: scoreboard bench; a cursor model queues expected cell writes
module tb_term_char_writer;
  import term_char_writer_pkg::*;
  localparam int C = 10, R = 6;
  typedef struct packed {logic [7:0] h; logic [7:0] v; logic [5:0] d; logic sw;} wr_t;
  logic clk = 0, rst = 0, in_valid = 0, in_ready, w_en, busy;
  logic [1:0] in_cmd = '0;
  logic [5:0] in_char = '0, w_data;
  logic [7:0] w_h_addr, w_v_addr, cur_h, cur_v;
  wr_t q[$];
  wr_t mon_e;
  int n_tests = 0, n_fail = 0, wcount = 0, mh = 0, mv = 0, base = 0;

  term_char_writer #(.COLS(C), .ROWS(R), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_char(in_char), .w_h_addr(w_h_addr), .w_v_addr(w_v_addr), .w_data(w_data),
    .w_en(w_en), .cur_h(cur_h), .cur_v(cur_v), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int h, input int v, input logic [5:0] d, input logic sw);
    q.push_back(wr_t'{h: 8'(h), v: 8'(v), d: d, sw: sw});
  endtask

  task automatic push_line(input int row);
    for (int c = 0; c < C; c++) push(c, row, CHAR_SPACE, 1'b1);
  endtask

  task automatic push_all();
    for (int r = 0; r < R; r++) push_line(r);
    mh = 0;
    mv = 0;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [5:0] ch, input bit hold = 0);
    case (cmd)
      CMD_PRINT: begin
        push(mh, mv, ch, 1'b0);
        if (mh == C - 1) begin
          mh = 0;
          mv = (mv + 1) % R;
          push_line(mv);
        end else mh++;
      end
      CMD_NEWLINE: begin
        mh = 0;
        mv = (mv + 1) % R;
        push_line(mv);
      end
      CMD_BACKSPACE: begin
        if (mh > 0) begin
          mh--;
          push(mh, mv, CHAR_SPACE, 1'b0);
        end else if (mv > 0) begin
          mv--;
          mh = C - 1;
          push(mh, mv, CHAR_SPACE, 1'b0);
        end
      end
      default: push_all();
    endcase
    in_valid = 1;
    in_cmd = cmd;
    in_char = ch;
    for (int i = 0; i < 400 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("accept_wait", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && !(in_ready && q.size() == 0); i++) begin
      @(posedge clk);
      #1;
    end
    check("queue_drained", q.size(), 0);
    check("idle_ready", 32'(in_ready), 1);
  endtask

  task automatic check_cur(input string tag, input int h, input int v);
    check({tag, "_h"}, 32'(cur_h), h);
    check({tag, "_v"}, 32'(cur_v), v);
  endtask

  always @(negedge clk)
    if (rst && w_en) begin
      wcount++;
      if (q.size() == 0) check("extra_write", 32'(w_en), 0);
      else begin
        mon_e = q.pop_front();
        check("w_h_addr", 32'(w_h_addr), 32'(mon_e.h));
        check("w_v_addr", 32'(w_v_addr), 32'(mon_e.v));
        check("w_data", 32'(w_data), 32'(mon_e.d));
        if (mon_e.sw) check("sweep_busy", 32'(busy), 1);
      end
    end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_w_en", 32'(w_en), 0);
    check("rst_w_h", 32'(w_h_addr), 0);
    check("rst_w_v", 32'(w_v_addr), 0);
    check("rst_w_data", 32'(w_data), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 1);
    check_cur("rst_cur", 0, 0);
    push_all();
    #2 rst = 1;
    wait_idle();
    check("boot_writes", wcount, C * R);
    check_cur("boot_cur", 0, 0);
    check("boot_busy", 32'(busy), 0);

    send(CMD_PRINT, CHAR_A);
    check("rdy_low_after_print", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("rdy_back_after_print", 32'(in_ready), 1);
    send(CMD_PRINT, CHAR_N);
    send(CMD_PRINT, CHAR_T);
    wait_idle();
    check_cur("ant_cur", 3, 0);

    for (int i = 0; i < 5; i++) send(CMD_NEWLINE, 6'd0);
    wait_idle();
    check_cur("row5_cur", 0, 5);
    for (int i = 0; i < C; i++) send(CMD_PRINT, 6'(CHAR_A + 6'(i)));
    wait_idle();
    check_cur("wrap_cur", 0, 0);

    send(CMD_NEWLINE, 6'd0);
    send(CMD_NEWLINE, 6'd0);
    wait_idle();
    send(CMD_BACKSPACE, 6'd0);
    wait_idle();
    check_cur("bs_row_cur", C - 1, 1);
    send(CMD_CLEAR, 6'd0);
    wait_idle();
    check_cur("clear_cur", 0, 0);
    base = wcount;
    send(CMD_BACKSPACE, 6'd0);
    check("bs_origin_rdy_low", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("bs_origin_rdy_back", 32'(in_ready), 1);
    check("bs_origin_nowrite", wcount - base, 0);
    check_cur("bs_origin_cur", 0, 0);

    for (int i = 0; i < 3; i++) send(CMD_NEWLINE, 6'd0);
    for (int i = 0; i < 4; i++) send(CMD_PRINT, CHAR_T);
    wait_idle();
    check_cur("nl_start_cur", 4, 3);
    send(CMD_NEWLINE, 6'd0, 1);
    check_cur("nl_cur", 0, 4);
    send(CMD_PRINT, CHAR_W);
    wait_idle();
    check_cur("w_cur", 1, 4);

    base = wcount;
    send(CMD_CLEAR, 6'd0);
    for (int i = 0; i < 300 && wcount - base < 30; i++) begin
      @(negedge clk);
      #1;
    end
    check("clear_reached_30", wcount - base, 30);
    rst = 0;
    #1;
    check("abort_w_en", 32'(w_en), 0);
    check("abort_ready", 32'(in_ready), 0);
    check("abort_busy", 32'(busy), 1);
    check_cur("abort_cur", 0, 0);
    q.delete();
    push_all();
    repeat (2) @(negedge clk);
    #2 rst = 1;
    base = wcount;
    wait_idle();
    check("restart_writes", wcount - base, C * R);
    check_cur("restart_cur", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
